// File: rtl/led_fade_driver.sv
// led_fade_driver
//
// Turns a slowly changing on/off LED pattern into per-LED PWM drive. Lit LEDs
// run at the programmed brightness. LEDs that turn off fade linearly to dark.
//
// Ports
//   clock        sole clock, rising edge
//   reset        asynchronous, active-high; clears every register
//   led_in       requested on/off pattern (WIDTH bits)
//   brightness   duty applied to lit LEDs (PWM_BITS bits)
//   io_led       registered PWM drive to the pins (WIDTH bits)
//   frame_start  registered one-cycle pulse in the cycle where pwm_cnt == 0
//
// Parameters
//   WIDTH          number of LEDs
//   PWM_BITS       PWM / brightness resolution, MAX = 2**PWM_BITS - 1
//   DECAY_DIV_BITS decay prescaler width, one decay tick per 2**DECAY_DIV_BITS cycles
//   DECAY_STEP     level decrement per decay tick (<= MAX)

module led_fade_driver #(
  parameter int WIDTH          = 24,
  parameter int PWM_BITS       = 8,
  parameter int DECAY_DIV_BITS = 16,
  parameter int DECAY_STEP     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [WIDTH-1:0]    io_led,
  output logic                frame_start
);

  localparam logic [PWM_BITS-1:0]       PWM_MAX   = '1;
  localparam logic [PWM_BITS-1:0]       PWM_ONE   = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0]       STEP_V    = PWM_BITS'(DECAY_STEP);
  localparam logic [DECAY_DIV_BITS-1:0] PRESC_ONE = DECAY_DIV_BITS'(1);

  // Registers
  logic [WIDTH-1:0]                led_q,         led_d;
  logic [WIDTH-1:0][PWM_BITS-1:0]  level_q,       level_d;
  logic [WIDTH-1:0][PWM_BITS-1:0]  shadow_q,      shadow_d;
  logic [PWM_BITS-1:0]             pwm_cnt_q,     pwm_cnt_d;
  logic [DECAY_DIV_BITS-1:0]       presc_q,       presc_d;
  logic [WIDTH-1:0]                io_led_q,      io_led_d;
  logic                            frame_start_q, frame_start_d;

  logic decay_tick;
  logic frame_end;

  always_comb begin
    led_d         = led_in;
    presc_d       = presc_q + PRESC_ONE;
    pwm_cnt_d     = pwm_cnt_q + PWM_ONE;
    decay_tick    = &presc_q;
    frame_end     = (pwm_cnt_q == PWM_MAX);
    frame_start_d = frame_end;

    level_d  = level_q;
    shadow_d = shadow_q;
    io_led_d = '0;

    for (int i = 0; i < WIDTH; i++) begin
      // A lit LED always tracks brightness, even on a decay tick, so a
      // re-lit LED jumps straight back with no residual fade.
      if (led_q[i]) begin
        level_d[i] = brightness;
      end else if (decay_tick) begin
        // Guarded subtract: saturates at dark instead of wrapping.
        level_d[i] = (level_q[i] >= STEP_V) ? (level_q[i] - STEP_V) : '0;
      end

      // Duty is latched only at the frame boundary so a frame never mixes
      // two levels; decay ticks between boundaries are simply overwritten.
      if (frame_end) begin
        shadow_d[i] = level_q[i];
      end

      // Strict compare: high count per frame equals the shadow value.
      io_led_d[i] = (shadow_q[i] > pwm_cnt_q);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_q         <= '0;
      level_q       <= '0;
      shadow_q      <= '0;
      pwm_cnt_q     <= '0;
      presc_q       <= '0;
      io_led_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      led_q         <= led_d;
      level_q       <= level_d;
      shadow_q      <= shadow_d;
      pwm_cnt_q     <= pwm_cnt_d;
      presc_q       <= presc_d;
      io_led_q      <= io_led_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign io_led      = io_led_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Testbench for led_fade_driver with WIDTH=4, PWM_BITS=4, DECAY_DIV_BITS=3,
// DECAY_STEP=4: directed scenarios with fixed expectations plus a randomized
// run against a behavioural model.

module tb_led_fade_driver;

  localparam int WIDTH          = 4;
  localparam int PWM_BITS       = 4;
  localparam int DECAY_DIV_BITS = 3;
  localparam int DECAY_STEP     = 4;
  localparam int FRAME          = 1 << PWM_BITS;
  localparam int DECAY_PERIOD   = 1 << DECAY_DIV_BITS;

  logic                clock = 1'b0;
  logic                reset;
  logic [WIDTH-1:0]    led_in;
  logic [PWM_BITS-1:0] brightness;
  logic [WIDTH-1:0]    io_led;
  logic                frame_start;

  int n_checks = 0;
  int n_pass   = 0;

  led_fade_driver #(
    .WIDTH(WIDTH),
    .PWM_BITS(PWM_BITS),
    .DECAY_DIV_BITS(DECAY_DIV_BITS),
    .DECAY_STEP(DECAY_STEP)
  ) dut (
    .clock(clock),
    .reset(reset),
    .led_in(led_in),
    .brightness(brightness),
    .io_led(io_led),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  // Behavioural model: m_cyc counts edges since reset, so the PWM position
  // and decay ticks follow from plain modular arithmetic.
  logic [WIDTH-1:0] m_led;
  logic [WIDTH-1:0] m_io;
  logic             m_fs;
  int               m_level[WIDTH];
  int               m_shadow[WIDTH];
  int               m_cyc;

  always @(posedge clock or posedge reset) begin : model
    int pos;
    bit tick;
    if (reset) begin
      m_led <= '0;
      m_io  <= '0;
      m_fs  <= 1'b0;
      m_cyc <= 0;
      for (int i = 0; i < WIDTH; i++) begin
        m_level[i]  <= 0;
        m_shadow[i] <= 0;
      end
    end else begin
      pos  = m_cyc % FRAME;
      tick = ((m_cyc % DECAY_PERIOD) == DECAY_PERIOD - 1);
      for (int i = 0; i < WIDTH; i++) begin
        m_io[i] <= (pos < m_shadow[i]);
        if (pos == FRAME - 1) m_shadow[i] <= m_level[i];
        if (m_led[i])
          m_level[i] <= int'(brightness);
        else if (tick)
          m_level[i] <= (m_level[i] - DECAY_STEP < 0) ? 0 : m_level[i] - DECAY_STEP;
      end
      m_fs  <= (pos == FRAME - 1);
      m_led <= led_in;
      m_cyc <= m_cyc + 1;
    end
  end

  // Frame measurement (no comparisons): waits for frame_start if not already
  // on it, then records the next FRAME cycles of io_led.
  int meas_hi[WIDTH];
  int meas_first[WIDTH];
  int meas_last[WIDTH];
  bit meas_to;

  task automatic measure_frame();
    int w;
    for (int i = 0; i < WIDTH; i++) begin
      meas_hi[i]    = 0;
      meas_first[i] = -1;
      meas_last[i]  = -1;
    end
    w = 0;
    while (frame_start !== 1'b1 && w < 2 * FRAME) begin
      @(negedge clock);
      w++;
    end
    meas_to = (frame_start !== 1'b1);
    if (!meas_to) begin
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clock);
        for (int i = 0; i < WIDTH; i++) begin
          if (io_led[i] === 1'b1) begin
            if (meas_first[i] < 0) meas_first[i] = c;
            meas_last[i] = c;
            meas_hi[i]++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if (io_led !== '0 || frame_start !== 1'b0)
      $display("FAIL reset_hold: io_led=%b frame_start=%b, expected 0000 and 0", io_led, frame_start);
    else n_pass++;

    led_in     = 4'b1111;
    brightness = 4'd15;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= 52; c++) begin
      @(negedge clock);
      n_checks++;
      if (frame_start !== ((c % FRAME) == 0))
        $display("FAIL fs_period: cycle %0d frame_start=%b expected %b", c, frame_start, (c % FRAME) == 0);
      else n_pass++;
      if (c == 20 || c == 52) begin
        n_checks++;
        if (io_led !== 4'hF)
          $display("FAIL lit_before_reset: cycle %0d io_led=%b expected 1111", c, io_led);
        else n_pass++;
      end
    end

    // Mid-frame asynchronous reset, checked before the next clock edge.
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (io_led !== '0 || frame_start !== 1'b0)
      $display("FAIL async_reset: io_led=%b frame_start=%b, expected 0000 and 0", io_led, frame_start);
    else n_pass++;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clock);
      n_checks++;
      if (frame_start !== (c == FRAME))
        $display("FAIL fs_after_rerelease: cycle %0d frame_start=%b expected %b", c, frame_start, c == FRAME);
      else n_pass++;
    end
  endtask

  task automatic test_duty();
    led_in     = 4'b0001;
    brightness = 4'd4;
    repeat (4) measure_frame();
    n_checks++;
    if (meas_to) $display("FAIL duty4_timeout: frame_start not seen");
    else n_pass++;
    n_checks++;
    if (meas_hi[0] !== 4 || meas_first[0] !== 0 || meas_last[0] !== 3)
      $display("FAIL duty4: hi=%0d first=%0d last=%0d expected 4 0 3", meas_hi[0], meas_first[0], meas_last[0]);
    else n_pass++;
    n_checks++;
    if (meas_hi[1] + meas_hi[2] + meas_hi[3] !== 0)
      $display("FAIL duty4_others: highs=%0d/%0d/%0d expected 0", meas_hi[1], meas_hi[2], meas_hi[3]);
    else n_pass++;

    brightness = 4'd15;
    repeat (2) measure_frame();
    n_checks++;
    if (meas_hi[0] !== 15 || meas_first[0] !== 0)
      $display("FAIL duty15: hi=%0d first=%0d expected 15 0", meas_hi[0], meas_first[0]);
    else n_pass++;

    brightness = 4'd0;
    repeat (2) measure_frame();
    n_checks++;
    if (meas_hi[0] !== 0 || meas_hi[1] + meas_hi[2] + meas_hi[3] !== 0)
      $display("FAIL duty0: hi0=%0d others=%0d expected 0 0", meas_hi[0], meas_hi[1] + meas_hi[2] + meas_hi[3]);
    else n_pass++;
  endtask

  task automatic test_double_buffer();
    int hits;
    int w;
    led_in = 4'b0000;
    measure_frame();
    brightness = 4'd15;
    repeat (5) @(negedge clock);
    led_in = 4'b0010;
    hits = 0;
    w    = 0;
    do begin
      @(negedge clock);
      if (io_led[1] === 1'b1) hits++;
      w++;
    end while (frame_start !== 1'b1 && w < FRAME);
    n_checks++;
    if (frame_start !== 1'b1 || hits !== 0)
      $display("FAIL dbuf_mid_frame: highs=%0d fs=%b expected 0 highs before frame_start", hits, frame_start);
    else n_pass++;
    measure_frame();
    n_checks++;
    if (meas_hi[1] !== 15 || meas_first[1] !== 0 || meas_last[1] !== 14)
      $display("FAIL dbuf_next_frame: hi=%0d first=%0d last=%0d expected 15 0 14", meas_hi[1], meas_first[1], meas_last[1]);
    else n_pass++;
  endtask

  task automatic test_decay();
    int exp_l2[9] = '{15, 11, 7, 3, 0, 0, 0, 0, 0};
    int exp_w2[4] = '{15, 11, 3, 0};
    int wh2[4]    = '{0, 0, 0, 0};
    int wh3[4]    = '{0, 0, 0, 0};
    led_in     = 4'b1100;
    brightness = 4'd15;
    repeat (2) measure_frame();
    n_checks++;
    if (meas_to || meas_hi[2] !== 15 || meas_hi[3] !== 15)
      $display("FAIL decay_lit: hi2=%0d hi3=%0d to=%b expected 15 15 0", meas_hi[2], meas_hi[3], meas_to);
    else n_pass++;

    led_in = 4'b1000;
    for (int c = 1; c <= 4 * FRAME; c++) begin
      @(negedge clock);
      if (io_led[2] === 1'b1) wh2[(c - 1) / FRAME]++;
      if (io_led[3] === 1'b1) wh3[(c - 1) / FRAME]++;
      if (c == 7 || (c % DECAY_PERIOD) == 0) begin
        n_checks++;
        if (int'(dut.level_q[2]) !== exp_l2[c / DECAY_PERIOD])
          $display("FAIL decay_level: cycle %0d level2=%0d expected %0d", c, dut.level_q[2], exp_l2[c / DECAY_PERIOD]);
        else n_pass++;
      end
      if (c == 8 || c == 16) begin
        n_checks++;
        if (int'(dut.level_q[3]) !== 15)
          $display("FAIL lit_over_tick: cycle %0d level3=%0d expected 15", c, dut.level_q[3]);
        else n_pass++;
      end
    end
    for (int f = 0; f < 4; f++) begin
      n_checks++;
      if (wh2[f] !== exp_w2[f] || wh3[f] !== 15)
        $display("FAIL decay_frame: frame %0d hi2=%0d hi3=%0d expected %0d 15", f, wh2[f], wh3[f], exp_w2[f]);
      else n_pass++;
    end
  endtask

  task automatic test_relight();
    led_in     = 4'b1100;
    brightness = 4'd15;
    repeat (2) measure_frame();
    led_in = 4'b1000;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      if (c == 24 || c == 25) begin
        n_checks++;
        if (int'(dut.level_q[2]) !== 3)
          $display("FAIL relight_pre: cycle %0d level2=%0d expected 3", c, dut.level_q[2]);
        else n_pass++;
      end
      if (c == 25) begin
        n_checks++;
        if (int'(dut.level_q[3]) !== 9)
          $display("FAIL bright_change: level3=%0d expected 9", dut.level_q[3]);
        else n_pass++;
      end
      if (c == 26 || c == 32) begin
        n_checks++;
        if (int'(dut.level_q[2]) !== 9)
          $display("FAIL relight: cycle %0d level2=%0d expected 9", c, dut.level_q[2]);
        else n_pass++;
      end
      if (c == 24) begin
        led_in     = 4'b1100;
        brightness = 4'd9;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      @(negedge clock);
      n_checks++;
      if (io_led !== m_io || frame_start !== m_fs)
        $display("FAIL random: step %0d io_led=%b fs=%b expected %b %b", k, io_led, frame_start, m_io, m_fs);
      else n_pass++;
      if (k == 200) begin
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (io_led !== '0 || frame_start !== 1'b0)
          $display("FAIL random_reset: io_led=%b fs=%b expected 0000 0", io_led, frame_start);
        else n_pass++;
      end else if (k == 203) begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 9) == 0) led_in = WIDTH'($urandom);
      if ($urandom_range(0, 29) == 0) brightness = PWM_BITS'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    led_in     = '0;
    brightness = '0;
    test_reset();
    test_duty();
    test_double_buffer();
    test_decay();
    test_relight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
